// File: rtl/bnn_weight_loader.sv
// Weight loader: fetches NUM_WORDS ROM words for one layer's binary kernel and
// commits them atomically to weight_o, with a registered per-channel slice.
module bnn_weight_loader #(
   parameter  int ADDR_WIDTH  = 8,
   parameter  int DATA_WIDTH  = 32,
   parameter  int NUM_WORDS   = 2,
   parameter  int KERNEL      = 7,
   parameter  int OUT_CH      = 8,
   localparam int WEIGHT_BITS = KERNEL * OUT_CH,
   localparam int CH_W        = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  base_addr,
   output logic                   rom_en,
   output logic [ADDR_WIDTH-1:0]  rom_addr,
   input  logic [DATA_WIDTH-1:0]  rom_data,
   output logic                   busy,
   output logic                   done,
   output logic                   weight_valid,
   output logic [WEIGHT_BITS-1:0] weight_o,
   input  logic [CH_W-1:0]        ch_sel,
   output logic [KERNEL-1:0]      ch_weight_o
);
   localparam int IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int SET_BITS = NUM_WORDS * DATA_WIDTH;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t               state;
   logic [IDX_W-1:0]     cnt;
   logic [IDX_W-1:0]     rd_idx;
   logic                 rd_vld;
   logic [SET_BITS-1:0]  shadow;
   logic [SET_BITS-1:0]  full_set;
   logic [KERNEL-1:0]    slice;

   // The last word is merged straight from the ROM bus so commit lands on its capture edge.
   always_comb begin
      full_set = shadow;
      full_set[(NUM_WORDS-1)*DATA_WIDTH +: DATA_WIDTH] = rom_data;
   end

   // Decoded channel mux; out-of-range selects fall through to zero.
   always_comb begin
      slice = '0;
      for (int c = 0; c < OUT_CH; c++)
         if (ch_sel == CH_W'(c)) slice = weight_o[c*KERNEL +: KERNEL];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         rd_idx       <= '0;
         rd_vld       <= 1'b0;
         shadow       <= '0;
         rom_en       <= 1'b0;
         rom_addr     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         weight_valid <= 1'b0;
         weight_o     <= '0;
         ch_weight_o  <= '0;
      end else begin
         done        <= 1'b0;
         ch_weight_o <= slice;
         // One-stage tag pipe matching the ROM's single-cycle read latency.
         rd_vld      <= rom_en;
         rd_idx      <= cnt;
         if (rd_vld) shadow[rd_idx*DATA_WIDTH +: DATA_WIDTH] <= rom_data;

         case (state)
            IDLE: if (start) begin
               rom_en   <= 1'b1;
               rom_addr <= base_addr;
               busy     <= 1'b1;
               cnt      <= '0;
               state    <= FETCH;
            end
            FETCH: if (cnt == LAST) begin
               rom_en <= 1'b0;
               state  <= DRAIN;
            end else begin
               rom_addr <= rom_addr + ADDR_WIDTH'(1);
               cnt      <= cnt + IDX_W'(1);
            end
            DRAIN: if (rd_vld && rd_idx == LAST) begin
               weight_o     <= WEIGHT_BITS'(full_set);
               weight_valid <= 1'b1;
               done         <= 1'b1;
               busy         <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bnn_weight_loader.sv
// Scoreboard bench for bnn_weight_loader: three configurations (2x32, 1x16, 4x16),
// expected commits queued at start and matched by a done monitor.
module tb_bnn_weight_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // u0: default config
   logic        start0, rom_en0, busy0, done0, wv0;
   logic [7:0]  base0, rom_addr0;
   logic [31:0] rom_data0;
   logic [55:0] w0;
   logic [2:0]  chs0;
   logic [6:0]  chw0;
   // u1: NUM_WORDS=1, DATA_WIDTH=16, KERNEL=3, OUT_CH=5
   logic        start1, rom_en1, busy1, done1, wv1;
   logic [7:0]  base1, rom_addr1;
   logic [15:0] rom_data1;
   logic [14:0] w1;
   logic [2:0]  chs1;
   logic [2:0]  chw1;
   // u2: NUM_WORDS=4, DATA_WIDTH=16, KERNEL=7, OUT_CH=6
   logic        start2, rom_en2, busy2, done2, wv2;
   logic [7:0]  base2, rom_addr2;
   logic [15:0] rom_data2;
   logic [41:0] w2;
   logic [2:0]  chs2;
   logic [6:0]  chw2;

   bnn_weight_loader u0 (
      .clk(clk), .rst(rst), .start(start0), .base_addr(base0), .rom_en(rom_en0),
      .rom_addr(rom_addr0), .rom_data(rom_data0), .busy(busy0), .done(done0),
      .weight_valid(wv0), .weight_o(w0), .ch_sel(chs0), .ch_weight_o(chw0));

   bnn_weight_loader #(.DATA_WIDTH(16), .NUM_WORDS(1), .KERNEL(3), .OUT_CH(5)) u1 (
      .clk(clk), .rst(rst), .start(start1), .base_addr(base1), .rom_en(rom_en1),
      .rom_addr(rom_addr1), .rom_data(rom_data1), .busy(busy1), .done(done1),
      .weight_valid(wv1), .weight_o(w1), .ch_sel(chs1), .ch_weight_o(chw1));

   bnn_weight_loader #(.DATA_WIDTH(16), .NUM_WORDS(4), .KERNEL(7), .OUT_CH(6)) u2 (
      .clk(clk), .rst(rst), .start(start2), .base_addr(base2), .rom_en(rom_en2),
      .rom_addr(rom_addr2), .rom_data(rom_data2), .busy(busy2), .done(done2),
      .weight_valid(wv2), .weight_o(w2), .ch_sel(chs2), .ch_weight_o(chw2));

   logic [31:0] mem0 [256];
   logic [15:0] mem1 [256];
   logic [15:0] mem2 [256];
   logic [7:0]  log0[$], log1[$], log2[$];

   // ROM models (1-cycle read latency) plus issued-address logs.
   always @(posedge clk) begin
      if (rom_en0) begin rom_data0 <= mem0[rom_addr0]; log0.push_back(rom_addr0); end
      if (rom_en1) begin rom_data1 <= mem1[rom_addr1]; log1.push_back(rom_addr1); end
      if (rom_en2) begin rom_data2 <= mem2[rom_addr2]; log2.push_back(rom_addr2); end
   end

   typedef struct { logic [63:0] w; int due; } exp_t;
   exp_t q0[$], q1[$], q2[$];
   int checks = 0, failures = 0;
   int donecnt0 = 0;

   always @(negedge clk) begin
      exp_t e;
      if (done0) begin
         donecnt0++;
         checks++;
         if (q0.size() == 0) begin
            failures++; $display("FAIL done0_spurious: got done=1 required no done");
         end else begin
            e = q0.pop_front();
            if (cyc != e.due || 64'(w0) !== e.w) begin
               failures++;
               $display("FAIL done0_commit: got cyc %0d w %0h required cyc %0d w %0h", cyc, w0, e.due, e.w);
            end
         end
      end
      if (done1) begin
         checks++;
         if (q1.size() == 0) begin
            failures++; $display("FAIL done1_spurious: got done=1 required no done");
         end else begin
            e = q1.pop_front();
            if (cyc != e.due || 64'(w1) !== e.w) begin
               failures++;
               $display("FAIL done1_commit: got cyc %0d w %0h required cyc %0d w %0h", cyc, w1, e.due, e.w);
            end
         end
      end
      if (done2) begin
         checks++;
         if (q2.size() == 0) begin
            failures++; $display("FAIL done2_spurious: got done=1 required no done");
         end else begin
            e = q2.pop_front();
            if (cyc != e.due || 64'(w2) !== e.w) begin
               failures++;
               $display("FAIL done2_commit: got cyc %0d w %0h required cyc %0d w %0h", cyc, w2, e.due, e.w);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge E0.
   task automatic issue(input int d, input logic [7:0] b, input logic [63:0] w);
      exp_t e;
      e.w = w;
      case (d)
         0: begin start0 = 1'b1; base0 = b; e.due = cyc + 2 + 2; q0.push_back(e); end
         1: begin start1 = 1'b1; base1 = b; e.due = cyc + 1 + 2; q1.push_back(e); end
         default: begin start2 = 1'b1; base2 = b; e.due = cyc + 4 + 2; q2.push_back(e); end
      endcase
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
   endtask

   task automatic drain(input int d);
      int nw;
      nw = (d == 0) ? 2 : (d == 1) ? 1 : 4;
      repeat (nw + 3) @(negedge clk);
      case (d)
         0: begin chk("pending0", 64'(q0.size()), 64'd0); q0.delete(); end
         1: begin chk("pending1", 64'(q1.size()), 64'd0); q1.delete(); end
         default: begin chk("pending2", 64'(q2.size()), 64'd0); q2.delete(); end
      endcase
   endtask

   localparam logic [55:0] W_BASIC = 56'h00CAFE_A5A51234;
   localparam logic [55:0] W_WRAP  = 56'hA51234_01234567;
   localparam logic [55:0] W_A     = 56'h543210_DEADBEEF;
   localparam logic [55:0] W_B     = 56'hABCDEF_0F0F0F0F;

   int n, dc;
   int     s0_sel [4] = '{0, 1, 7, 3};
   logic [6:0] s0_exp [4] = '{7'h34, 7'h24, 7'h00, 7'h2D};
   int     s1_sel [4] = '{0, 4, 2, 5};
   logic [2:0] s1_exp [4] = '{3'h7, 3'h3, 3'h3, 3'h0};
   int     s2_sel [4] = '{0, 5, 6, 7};
   logic [6:0] s2_exp [4] = '{7'h34, 7'h57, 7'h00, 7'h00};

   initial begin
      start0 = 0; start1 = 0; start2 = 0;
      base0 = 0; base1 = 0; base2 = 0;
      chs0 = 0; chs1 = 0; chs2 = 0;
      for (int i = 0; i < 256; i++) begin
         mem0[i] = 32'h5A000000 | i; mem1[i] = 16'h0F00 | 16'(i); mem2[i] = 16'h3300 | 16'(i);
      end
      mem0[0] = 32'hA5A5_1234; mem0[1] = 32'hFF00_CAFE; mem0[255] = 32'h0123_4567;
      mem0[2] = 32'hDEAD_BEEF; mem0[3] = 32'h7654_3210;
      mem0[4] = 32'h0F0F_0F0F; mem0[5] = 32'h00AB_CDEF;
      mem1[10] = 16'hBEEF;
      mem2[100] = 16'h1234; mem2[101] = 16'h5678; mem2[102] = 16'h9ABC; mem2[103] = 16'hDEF0;
      mem2[254] = 16'hAAAA; mem2[255] = 16'h5555; mem2[0] = 16'h0001; mem2[1] = 16'h8000;

      repeat (3) @(negedge clk);
      chk("rst_rom_en", 64'(rom_en0), 0);
      chk("rst_rom_addr", 64'(rom_addr0), 0);
      chk("rst_busy", 64'(busy0), 0);
      chk("rst_done", 64'(done0), 0);
      chk("rst_valid", 64'(wv0), 0);
      chk("rst_weight", 64'(w0), 0);
      chk("rst_slice", 64'(chw0), 0);
      rst = 1'b0;
      @(negedge clk);

      // basic load and cycle-by-cycle handshake
      n = log0.size();
      issue(0, 8'd0, 64'(W_BASIC));
      chk("e0_busy", 64'(busy0), 1);
      chk("e0_rom_en", 64'(rom_en0), 1);
      chk("e0_addr", 64'(rom_addr0), 0);
      @(negedge clk);
      chk("e1_addr", 64'(rom_addr0), 1);
      chk("e1_valid", 64'(wv0), 0);
      @(negedge clk);
      chk("e2_rom_en", 64'(rom_en0), 0);
      chk("e2_busy", 64'(busy0), 1);
      @(negedge clk);
      chk("e3_done", 64'(done0), 1);
      chk("e3_busy", 64'(busy0), 0);
      chk("e3_valid", 64'(wv0), 1);
      @(negedge clk);
      chk("e4_done", 64'(done0), 0);
      chk("basic_rd_count", 64'(log0.size() - n), 2);
      chk("basic_addr0", 64'(log0[n]), 0);
      chk("basic_addr1", 64'(log0[n+1]), 1);
      chk("basic_pending", 64'(q0.size()), 0);

      for (int i = 0; i < 4; i++) begin
         chs0 = 3'(s0_sel[i]);
         @(negedge clk);
         chk($sformatf("slice0_ch%0d", s0_sel[i]), 64'(chw0), 64'(s0_exp[i]));
      end

      // address wrap
      n = log0.size();
      issue(0, 8'd255, 64'(W_WRAP));
      drain(0);
      chk("wrap_addr0", 64'(log0[n]), 255);
      chk("wrap_addr1", 64'(log0[n+1]), 0);
      chk("wrap_weight", 64'(w0), 64'(W_WRAP));

      // reload stability with ignored starts during busy and on the done edge
      issue(0, 8'd2, 64'(W_A));
      drain(0);
      n = log0.size();
      issue(0, 8'd4, 64'(W_B));
      chk("reload_e0_w", 64'(w0), 64'(W_A));
      chk("reload_e0_v", 64'(wv0), 1);
      start0 = 1'b1;
      @(negedge clk);
      chk("reload_e1_w", 64'(w0), 64'(W_A));
      chk("reload_e1_v", 64'(wv0), 1);
      @(negedge clk);
      chk("reload_e2_w", 64'(w0), 64'(W_A));
      @(negedge clk);
      start0 = 1'b0;
      chk("reload_e3_w", 64'(w0), 64'(W_B));
      chk("reload_e3_v", 64'(wv0), 1);
      repeat (5) @(negedge clk);
      chk("reload_rd_count", 64'(log0.size() - n), 2);
      chk("reload_pending", 64'(q0.size()), 0);

      // reset mid-load
      issue(0, 8'd6, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_rom_en", 64'(rom_en0), 0);
      chk("abort_addr", 64'(rom_addr0), 0);
      chk("abort_busy", 64'(busy0), 0);
      chk("abort_valid", 64'(wv0), 0);
      chk("abort_weight", 64'(w0), 0);
      chk("abort_slice", 64'(chw0), 0);
      rst = 1'b0;
      q0.delete();
      dc = donecnt0;
      repeat (6) @(negedge clk);
      chk("abort_no_done", 64'(donecnt0 - dc), 0);
      issue(0, 8'd0, 64'(W_BASIC));
      drain(0);
      chk("after_abort_w", 64'(w0), 64'(W_BASIC));
      chk("after_abort_v", 64'(wv0), 1);

      // NUM_WORDS=1
      issue(1, 8'd10, 64'h3EEF);
      chk("nw1_e0_busy", 64'(busy1), 1);
      @(negedge clk);
      chk("nw1_e1_busy", 64'(busy1), 1);
      drain(1);
      chk("nw1_valid", 64'(wv1), 1);
      for (int i = 0; i < 4; i++) begin
         chs1 = 3'(s1_sel[i]);
         @(negedge clk);
         chk($sformatf("slice1_ch%0d", s1_sel[i]), 64'(chw1), 64'(s1_exp[i]));
      end

      // NUM_WORDS=4, OUT_CH=6
      issue(2, 8'd100, 64'h2BC_5678_1234);
      drain(2);
      for (int i = 0; i < 4; i++) begin
         chs2 = 3'(s2_sel[i]);
         @(negedge clk);
         chk($sformatf("slice2_ch%0d", s2_sel[i]), 64'(chw2), 64'(s2_exp[i]));
      end
      n = log2.size();
      issue(2, 8'd254, 64'h0_0155_55AAAA);
      drain(2);
      chk("nw4_rd_count", 64'(log2.size() - n), 4);
      chk("nw4_wrap_a0", 64'(log2[n]), 254);
      chk("nw4_wrap_a1", 64'(log2[n+1]), 255);
      chk("nw4_wrap_a2", 64'(log2[n+2]), 0);
      chk("nw4_wrap_a3", 64'(log2[n+3]), 1);
      chk("nw4_valid", 64'(wv2), 1);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/bnn_weight_loader.md
# bnn_weight_loader

Sequencer that fetches one layer's packed binary convolution weights from the block weight ROM, which returns read data one cycle after the address is presented. It reassembles the weights into a single wide kernel register and presents them to the BNN convolution engine as a flat vector and as a per-output-channel slice. It sits directly downstream of the per-block weight ROMs and upstream of the XNOR/popcount PE array. A start/done handshake with the layer controller drives it.

## Interface
- ADDR_WIDTH, 8, ROM address width
- DATA_WIDTH, 32, ROM word width
- NUM_WORDS, 2, ROM words per weight set (≥1)
- KERNEL, 7, taps per output channel
- OUT_CH, 8, output channels; WEIGHT_BITS = KERNEL*OUT_CH (56) must be ≤ NUM_WORDS*DATA_WIDTH
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  load request, sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first ROM word of the set, captured with start
- rom_en  out  1  ROM read enable
- rom_addr  out  ADDR_WIDTH  ROM address
- rom_data  in  DATA_WIDTH  ROM read data, valid one cycle after rom_en
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the new set is committed
- weight_valid  out  1  weight_o holds a complete set
- weight_o  out  WEIGHT_BITS  committed weight vector
- ch_sel  in  clog2(OUT_CH)  channel select
- ch_weight_o  out  KERNEL  registered slice for ch_sel

## Operation
- All outputs are registered. Reset values: rom_en=0, rom_addr=0, busy=0, done=0, weight_valid=0, weight_o=0, ch_weight_o=0. The FSM resets to IDLE.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE → FETCH when start=1.
  - FETCH → DRAIN after NUM_WORDS addresses have been issued.
  - DRAIN → IDLE after the last word is captured.
- IDLE behaviour: on an edge with start=1, latch base_addr, then set rom_en=1, rom_addr=base_addr, busy=1.
- FETCH behaviour: one address per cycle, in the order base, base+1, …, base+NUM_WORDS-1. Address arithmetic is modulo 2^ADDR_WIDTH, so a set may wrap from 255 to 0. rom_en drops to 0 on the edge after the last address.
- Capture uses a one-stage valid/index pipeline that tracks the ROM latency. Word i lands in shadow[i*DATA_WIDTH +: DATA_WIDTH].
- Packing: weight bit j comes from bit j of the concatenated words, with word 0 as the LSBs. Channel c occupies bits [c*KERNEL +: KERNEL], and tap t of that channel is bit c*KERNEL+t. Bits at or above WEIGHT_BITS are discarded (bits 55..0 kept in the default configuration).
- Commit: on the edge that captures the last word, the following all happen on the same edge:
  - weight_o is loaded with the full set (shadow plus last word).
  - weight_valid is set to 1.
  - done is pulsed.
  - busy is cleared.
- weight_o is never partially updated. The previous set stays visible and valid throughout a reload.
- start while busy=1 is ignored and is not queued. start on the same edge as the done pulse is also ignored. A new load is accepted from the following cycle.
- Channel slice: every cycle, ch_weight_o <= weight_o[ch_sel*KERNEL +: KERNEL]. If ch_sel ≥ OUT_CH, ch_weight_o <= 0. The slice reflects weight_o as it was before the current edge.
- Reset mid-load aborts the load. State returns to IDLE, all outputs take their reset values, and no done pulse is produced. weight_valid is cleared only by reset.

## Timing
- Start accepted at edge E0.
  - rom_addr for word i is presented during cycle Ei..Ei+1.
  - Word i is captured at Ei+2.
- Commit/done occurs at edge E(NUM_WORDS+1). For the default configuration that is E3, so done is high in cycle E3..E4.
- busy is high from E0 to E(NUM_WORDS+1), which is NUM_WORDS+1 cycles.
- Back-to-back loads: minimum start-to-start spacing is NUM_WORDS+2 cycles.
- ch_weight_o latency: 1 cycle from a ch_sel change. After a commit, the slice reflects the new weights at the following edge.

## Test plan
- Basic load: ROM words {0xA5A5_1234, 0xFF00_CAFE}, base_addr=0, start at E0.
  - rom_addr sequence is 0, 1.
  - done at E3.
  - weight_o = 56'h00_CAFE_A5A5_1234.
  - weight_valid=1, busy lasts 3 cycles.
- Channel slices after the basic load:
  - ch_sel=0 → ch_weight_o=7'h34.
  - ch_sel=1 → 7'h24.
  - ch_sel=7 → bits 55..49 = 7'h00.
  - ch_sel out of range (none exist for OUT_CH=8; use OUT_CH=6 with ch_sel=6) → 0.
- Address wrap: base_addr=255.
  - rom_addr sequence is 255, 0.
  - The captured word order is preserved.
- Reload stability: load set A, then start set B.
  - weight_o equals A through E2 of the second load and equals B at E3.
  - weight_valid stays 1 throughout.
  - start pulses during busy produce no extra rom_en cycles.
- Reset mid-load: assert rst at E1.
  - The next cycle shows all outputs zero, FSM in IDLE, and no done pulse.
  - A subsequent start completes a normal load.
- Latency sweep: NUM_WORDS=1 and NUM_WORDS=4 (DATA_WIDTH=16).
  - done arrives exactly NUM_WORDS+1 edges after start.
  - Packing matches LSB-first concatenation.
